// File: rtl/axis2serial.sv
// axis2serial: SPI-mode-0 master that shifts a 32-bit AXI-Stream command
// stream MSB first onto mosi/sck/cs, gated by the receiver's cts at word
// boundaries. Counterpart of the Serial2AXIS slave receiver.
module axis2serial #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLOCK_DIV  = 2,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  serial_mosi,
  output logic                  serial_sck,
  output logic                  serial_cs,
  input  logic                  serial_cts,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_LO, SHIFT_HI, NEXT, HOLD, GAP
  } state_e;

  localparam int unsigned M1      = (CLOCK_DIV > CS_SETUP) ? CLOCK_DIV : CS_SETUP;
  localparam int unsigned M2      = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam int unsigned DIV_LAST   = (CLOCK_DIV > 0) ? CLOCK_DIV - 1 : 0;
  localparam int unsigned SETUP_LAST = (CS_SETUP > 0) ? CS_SETUP - 1 : 0;
  localparam int unsigned HOLD_LAST  = (CS_HOLD > 0) ? CS_HOLD - 1 : 0;
  localparam int unsigned GAP_LAST   = (CS_GAP > 0) ? CS_GAP - 1 : 0;

  // Zero-length setup/hold/gap phases are skipped entirely rather than
  // spending one cycle in a state whose count would underflow.
  localparam state_e SETUP_ENTRY = (CS_SETUP == 0) ? SHIFT_LO : SETUP;
  localparam state_e GAP_ENTRY   = (CS_GAP == 0) ? IDLE : GAP;
  localparam state_e HOLD_ENTRY  = (CS_HOLD == 0) ? GAP_ENTRY : HOLD;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic                    last_q, last_d;
  logic                    cts_meta_q, cts_s_q;
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic                    busy_q, busy_d;
  logic                    hs;

  assign hs          = s_axis_tvalid && s_axis_tready;
  assign serial_mosi = sr_q[DATA_WIDTH-1];
  assign serial_sck  = sck_q;
  assign serial_cs   = cs_q;
  assign busy        = busy_q;

  // State and registered-output update, with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      last_q     <= 1'b0;
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      last_q     <= last_d;
      cts_meta_q <= serial_cts;
      cts_s_q    <= cts_meta_q;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: phase counters, bit counter, word load and shift.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          sr_d    = s_axis_tdata;
          last_d  = s_axis_tlast;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SETUP_ENTRY;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_LAST)) begin
          cnt_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT_LO: begin
        if (cnt_q == CW'(DIV_LAST)) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_q == CW'(DIV_LAST)) begin
          cnt_d = '0;
          sr_d  = sr_q << 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = last_q ? HOLD_ENTRY : NEXT;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      NEXT: begin
        if (hs) begin
          sr_d    = s_axis_tdata;
          last_d  = s_axis_tlast;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_LAST)) begin
          cnt_d   = '0;
          state_d = GAP_ENTRY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_LAST)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: tready decoded from registered state, pins precomputed from next state.
  always_comb begin
    s_axis_tready = cts_s_q && ((state_q == IDLE) || (state_q == NEXT));
    cs_d          = (state_d == IDLE) || (state_d == GAP);
    sck_d         = (state_d == SHIFT_HI);
    busy_d        = (state_d != IDLE);
  end

endmodule

// File: tb/tb_axis2serial.sv
// Directed bench for axis2serial: table of words checked through a serial
// receiver model, plus hand sequences for timing, cts flow control and reset.
`timescale 1ns/1ps
module tb_axis2serial;

  logic        aclk;
  logic        reset;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [31:0] tdata;
  logic        mosi;
  logic        sck;
  logic        cs;
  logic        cts;
  logic        busy;

  axis2serial #(
    .DATA_WIDTH(32),
    .CLOCK_DIV (2),
    .CS_SETUP  (2),
    .CS_HOLD   (2),
    .CS_GAP    (4)
  ) dut (
    .aclk         (aclk),
    .reset        (reset),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tlast (tlast),
    .s_axis_tdata (tdata),
    .serial_mosi  (mosi),
    .serial_sck   (sck),
    .serial_cs    (cs),
    .serial_cts   (cts),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // receiver model state
  int          win_len, win_bits, high_len, last_low_len, last_bits;
  int          min_gap = 9999;
  bit          seen_rise, gap_track;
  int          rise_cyc [256];
  logic [31:0] sh;
  logic [31:0] rx_data [$];
  bit          rx_last [$];
  int          mosi_viol = 0;
  logic        sck_p, cs_p, mosi_p;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;
  vec_t vec [8];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  // Serial receiver: samples mosi on sck rising edges while cs is low.
  initial forever begin
    @(negedge aclk);
    if (cs === 1'b0 && cs_p === 1'b1) begin
      if (gap_track && seen_rise && high_len < min_gap) min_gap = high_len;
      win_len  = 0;
      win_bits = 0;
    end
    if (cs === 1'b0) begin
      win_len++;
      if (sck === 1'b1 && sck_p === 1'b0) begin
        if (win_bits < 256) rise_cyc[win_bits] = cyc;
        win_bits++;
        sh = {sh[30:0], mosi};
        if (win_bits % 32 == 0) begin
          rx_data.push_back(sh);
          rx_last.push_back(1'b0);
        end
      end
    end
    if (cs === 1'b1 && cs_p === 1'b0) begin
      last_low_len = win_len;
      last_bits    = win_bits;
      if (win_bits >= 32 && win_bits % 32 == 0 && rx_last.size() > 0)
        rx_last[rx_last.size()-1] = 1'b1;
      seen_rise = 1'b1;
      high_len  = 0;
    end
    if (cs === 1'b1) high_len++;
    if (sck === 1'b1 && mosi !== mosi_p) mosi_viol++;
    sck_p  = sck;
    cs_p   = cs;
    mosi_p = mosi;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake.
  task automatic send_word(input logic [31:0] d, input logic l, output int hs);
    bit ok;
    ok     = 1'b0;
    hs     = -1;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    for (int i = 0; i < 3000; i++) begin
      if (tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    if (ok) begin
      @(posedge aclk);
      @(negedge aclk);
      hs = cyc;
    end
    tvalid = 1'b0;
    tdata  = $urandom;
    tlast  = 1'($urandom_range(0, 1));
    chk("handshake_within_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      if (busy === 1'b0 && cs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge aclk);
    chk("idle_within_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_bits(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (win_bits >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    chk($sformatf("bits_%0d_within_bound", n), {31'd0, ok}, 32'd1);
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
  endtask

  initial begin
    int hs, hs2, r, bad;
    logic [31:0] exp_q [$];
    bit          expl_q [$];

    vec[0] = '{32'hA5C30F81, 1'b1, 32'hA5C30F81, 1'b1};
    vec[1] = '{32'h11223344, 1'b0, 32'h11223344, 1'b0};
    vec[2] = '{32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
    vec[3] = '{32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vec[4] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
    vec[5] = '{32'h80000001, 1'b0, 32'h80000001, 1'b0};
    vec[6] = '{32'h7FFFFFFE, 1'b1, 32'h7FFFFFFE, 1'b1};
    vec[7] = '{32'h55AA55AA, 1'b1, 32'h55AA55AA, 1'b1};

    reset  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    cts    = 1'b1;
    repeat (3) @(negedge aclk);
    chk("reset_cs", {31'd0, cs}, 32'd1);
    chk("reset_sck", {31'd0, sck}, 32'd0);
    chk("reset_mosi", {31'd0, mosi}, 32'd0);
    chk("reset_tready", {31'd0, tready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge aclk);
    chk("idle_tready", {31'd0, tready}, 32'd1);

    // single word: latency and frame length
    clear_rx();
    send_word(32'hA5C30F81, 1'b1, hs);
    chk("cs_low_after_hs", {31'd0, cs}, 32'd0);
    chk("mosi_msb_after_hs", {31'd0, mosi}, 32'd1);
    wait_idle();
    chk("single_first_rise_latency", rise_cyc[0] - hs, 32'd4);
    chk("single_rise_spacing", rise_cyc[1] - rise_cyc[0], 32'd4);
    chk("single_cs_low_len", last_low_len, 32'd132);
    chk("single_bits", last_bits, 32'd32);
    chk("single_rx_count", rx_data.size(), 32'd1);
    if (rx_data.size() >= 1) begin
      chk("single_rx_data", rx_data[0], 32'hA5C30F81);
      chk("single_rx_last", {31'd0, rx_last[0]}, 32'd1);
    end

    // two-word packet, tvalid held: one-cycle NEXT
    clear_rx();
    send_word(32'h11223344, 1'b0, hs);
    send_word(32'hDEADBEEF, 1'b1, hs2);
    wait_idle();
    chk("pkt2_bits", last_bits, 32'd64);
    chk("pkt2_cs_low_len", last_low_len, 32'd261);
    chk("pkt2_next_spacing", rise_cyc[32] - rise_cyc[31], 32'd5);
    chk("pkt2_rx_count", rx_data.size(), 32'd2);
    if (rx_data.size() >= 2) begin
      chk("pkt2_w0", rx_data[0], 32'h11223344);
      chk("pkt2_w0_last", {31'd0, rx_last[0]}, 32'd0);
      chk("pkt2_w1", rx_data[1], 32'hDEADBEEF);
      chk("pkt2_w1_last", {31'd0, rx_last[1]}, 32'd1);
    end

    // table of words, sent back-to-back
    clear_rx();
    gap_track = 1'b1;
    min_gap   = 9999;
    for (int i = 0; i < 8; i++) send_word(vec[i].data, vec[i].last, hs);
    wait_idle();
    gap_track = 1'b0;
    chk("table_rx_count", rx_data.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rx_data.size()) begin
        chk($sformatf("table_data_%0d", i), rx_data[i], vec[i].exp_data);
        chk($sformatf("table_last_%0d", i), {31'd0, rx_last[i]}, {31'd0, vec[i].exp_last});
      end
    end
    chk("table_cs_gap", min_gap, 32'd5);

    // cts low before the first beat
    clear_rx();
    cts = 1'b0;
    repeat (3) @(negedge aclk);
    tvalid = 1'b1;
    bad    = 0;
    for (int i = 0; i < 100; i++) begin
      tdata = $urandom;
      tlast = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (tready !== 1'b0 || cs !== 1'b1) bad++;
    end
    chk("cts_low_holdoff", bad, 32'd0);
    cts = 1'b1;
    r   = cyc;
    send_word(32'h12345678, 1'b1, hs);
    chk("cts_rise_latency", hs - r, 32'd3);
    wait_idle();
    chk("cts_rx_count", rx_data.size(), 32'd1);
    if (rx_data.size() >= 1) chk("cts_rx_data", rx_data[0], 32'h12345678);

    // cts dropped mid-word
    clear_rx();
    send_word(32'hC0FFEE11, 1'b0, hs);
    wait_bits(10);
    cts    = 1'b0;
    tvalid = 1'b1;
    tdata  = 32'h0BADF00D;
    tlast  = 1'b1;
    wait_bits(32);
    repeat (60) @(negedge aclk);
    chk("ctsmid_cs_low", {31'd0, cs}, 32'd0);
    chk("ctsmid_bits", win_bits, 32'd32);
    chk("ctsmid_tready", {31'd0, tready}, 32'd0);
    chk("ctsmid_busy", {31'd0, busy}, 32'd1);
    cts = 1'b1;
    send_word(32'h0BADF00D, 1'b1, hs);
    wait_idle();
    chk("ctsmid_rx_count", rx_data.size(), 32'd2);
    if (rx_data.size() >= 2) begin
      chk("ctsmid_w0", rx_data[0], 32'hC0FFEE11);
      chk("ctsmid_w1", rx_data[1], 32'h0BADF00D);
      chk("ctsmid_w1_last", {31'd0, rx_last[1]}, 32'd1);
    end

    // reset mid-word
    clear_rx();
    send_word(32'hFFFFFFFF, 1'b1, hs);
    wait_bits(17);
    reset = 1'b1;
    @(negedge aclk);
    chk("midrst_cs", {31'd0, cs}, 32'd1);
    chk("midrst_sck", {31'd0, sck}, 32'd0);
    chk("midrst_mosi", {31'd0, mosi}, 32'd0);
    chk("midrst_tready", {31'd0, tready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge aclk);
    send_word(32'h00000001, 1'b1, hs);
    wait_idle();
    chk("postrst_rx_count", rx_data.size(), 32'd1);
    if (rx_data.size() >= 1) begin
      chk("postrst_data", rx_data[0], 32'h00000001);
      chk("postrst_last", {31'd0, rx_last[0]}, 32'd1);
    end

    // reset coincident with a handshake: word must be refused
    clear_rx();
    chk("rstwin_tready_pre", {31'd0, tready}, 32'd1);
    reset  = 1'b1;
    tvalid = 1'b1;
    tdata  = 32'hCAFEBABE;
    tlast  = 1'b1;
    @(negedge aclk);
    tvalid = 1'b0;
    reset  = 1'b0;
    chk("rstwin_busy", {31'd0, busy}, 32'd0);
    chk("rstwin_cs", {31'd0, cs}, 32'd1);
    repeat (20) @(negedge aclk);
    chk("rstwin_rx_count", rx_data.size(), 32'd0);

    // random words in 16-word packets with random tvalid gaps
    clear_rx();
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 16; w++) begin
        logic [31:0] d;
        d = $urandom;
        repeat ($urandom_range(0, 3)) @(negedge aclk);
        send_word(d, (w == 15), hs);
        exp_q.push_back(d);
        expl_q.push_back(w == 15);
      end
    end
    wait_idle();
    chk("rand_rx_count", rx_data.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= rx_data.size() || rx_data[i] !== exp_q[i] || rx_last[i] !== expl_q[i]) bad++;
    end
    chk("rand_word_errors", bad, 32'd0);

    chk("mosi_stable_while_sck_high", mosi_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis2serial.md
Name: axis2serial

Overview:
- SPI-master transmitter that serialises a 32-bit AXI-Stream command stream onto the four-wire serial link (mosi/sck/cs, with cts flow control).
- It is the counterpart of Serial2AXIS, the slave receiver inside the RasteriCEr top level.
- Used in the host-side bridge and in loopback benches, where serial_* outputs drive Serial2AXIS directly and Serial2AXIS.serial_cts drives this block's serial_cts.

Parameters:
DATA_WIDTH, 32, stream word width; bits shifted per beat.
CLOCK_DIV, 2, aclk cycles per sck half-period (sck period = 2*CLOCK_DIV cycles); minimum 1.
CS_SETUP, 2, aclk cycles from serial_cs falling to the first sck half-period.
CS_HOLD, 2, aclk cycles from the last sck falling edge to serial_cs rising.
CS_GAP, 4, minimum aclk cycles serial_cs stays high between packets.

Ports:
aclk  input  1  clock, all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
s_axis_tvalid  input  1  stream word valid.
s_axis_tready  output  1  stream word accepted when tvalid and tready are both high.
s_axis_tlast  input  1  last word of a packet; serial_cs deasserts after this word.
s_axis_tdata  input  DATA_WIDTH  word, transmitted MSB first.
serial_mosi  output  1  serial data; changes only while sck is low.
serial_sck  output  1  serial clock, idle low (SPI mode 0; receiver samples on the rising edge).
serial_cs  output  1  chip select, active low.
serial_cts  input  1  clear-to-send from the receiver, asynchronous; high = may send.
busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset values: serial_cs=1, serial_sck=0, serial_mosi=0, s_axis_tready=0, busy=0, state=IDLE, cts synchroniser=0.
- serial_cts passes through a 2-flop synchroniser (cts_s) before use.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, NEXT, HOLD, GAP.
- s_axis_tready is combinational from registered state: it is 1 only in IDLE or NEXT, and only while cts_s=1.
- IDLE, with serial_cs=1:
  - On handshake in cycle T, latch tdata into the shift register and latch tlast.
  - At T+1: state=SETUP, serial_cs=0, serial_mosi=tdata[MSB].
- SETUP: count CS_SETUP cycles, then go to SHIFT_LO.
- SHIFT_LO: sck=0 for CLOCK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: sck=1 for CLOCK_DIV cycles. On exit, sck returns to 0 and the shift register shifts left, putting the next bit on mosi in that same cycle.
- Bit counter: counts DATA_WIDTH bits. After the last SHIFT_HI:
  - latched tlast=1 → HOLD;
  - latched tlast=0 → NEXT.
- First sck rising edge is at T+1+CS_SETUP+CLOCK_DIV.
- A word lasts DATA_WIDTH*2*CLOCK_DIV cycles (128 at the defaults).
- NEXT:
  - serial_cs stays 0, sck stays 0; wait for a handshake.
  - On handshake, load the word and go directly to SHIFT_LO (no SETUP).
  - Back-to-back gap between words is 1 cycle when tvalid and cts_s are both high.
- HOLD: CS_HOLD cycles with serial_cs=0 and sck=0, then serial_cs=1 and go to GAP.
- GAP: CS_GAP cycles with serial_cs=1, then IDLE. No handshake is possible in HOLD or GAP.
- Flow control: cts_s is evaluated only at word boundaries (IDLE and NEXT). A cts fall during SETUP/SHIFT does not abort or stretch the current word. While cts_s=0 in NEXT, serial_cs stays low indefinitely.
- tvalid high with tready low: the word is not consumed. tdata/tlast changing while tready=0 has no effect.
- Reset mid-operation: the next cycle shows reset values (serial_cs=1 immediately). The partial word is dropped and not re-sent. The receiver discards it because cs rises.
- Simultaneous reset and handshake: reset wins and the word is not accepted.
- Empty packet is impossible: every accepted word transmits all DATA_WIDTH bits.

Test Plan:
- Single word 0xA5C30F81 with tlast=1, defaults, cts=1 → serial_cs low for 2+128+2=132 cycles; exactly 32 sck rising edges; bits sampled on rising edges = 0xA5C30F81 MSB first; then serial_cs high ≥4 cycles; busy low afterwards.
- Two-word packet 0x11223344 (tlast=0), 0xDEADBEEF (tlast=1) with tvalid held high → serial_cs stays low across both words; NEXT lasts 1 cycle; 64 rising edges; receiver reassembles both words in order, with tlast on the second.
- cts=0 before the first beat → tready stays 0 and serial_cs stays 1 for 100 cycles. Raising cts → handshake 3 cycles later (synchroniser plus state), then transmission.
- cts dropped mid-word 10 → word completes all 32 bits; next word is held in NEXT with serial_cs low until cts returns; no data loss.
- Reset asserted at bit 17 of 0xFFFFFFFF → next cycle serial_cs=1, sck=0, mosi=0, tready=0. After release, word 0x00000001 (tlast=1) transmits correctly.
- Loopback with Serial2AXIS, CLOCK_DIV=2, 256 random words in 16-word packets with random tvalid gaps → all words received bit-exact in order, tlast positions match, and the receiver never overflows.
